// File: rtl/pattern_stream_sched.sv
// pattern_stream_sched
//
// Two requesters offer WIDTH-bit job words. A round-robin arbiter accepts one
// word at a time. The word is shifted MSB first, one bit per clock, through a
// single Mealy detector that counts overlapping "010" (cnt_a) and "101"
// (cnt_b) hits. After the last bit the counts are presented on the result port
// until the consumer takes them. Then the block returns to IDLE.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and its data stable until that edge.
// The req*_ready outputs depend combinationally on state and the valid inputs.
// res_valid comes from a register and does not depend on res_ready.
//
// Ports
//   clock, reset_n          clock; asynchronous active-low reset
//   req0_valid/data/ready   requester 0 job word handshake
//   req1_valid/data/ready   requester 1 job word handshake
//   res_valid, res_ready    result handshake
//   res_id                  requester that owns the result
//   res_cnt_a, res_cnt_b    saturating "010" / "101" hit counts
//   busy                    high whenever the FSM is not IDLE
//   dbg_state               current FSM state (0 IDLE, 1 SHIFT, 2 RESULT)
module pattern_stream_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic [CNT_W-1:0] res_cnt_a,
    output logic [CNT_W-1:0] res_cnt_b,
    input  logic             res_ready,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam int              BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic               r_id;
    logic               r_last;
    logic [BW-1:0]      r_bit_cnt;
    logic [1:0]         r_hist;
    logic [CNT_W-1:0]   r_cnt_a;
    logic [CNT_W-1:0]   r_cnt_b;
    logic               r_res_id;
    logic [CNT_W-1:0]   r_res_cnt_a;
    logic [CNT_W-1:0]   r_res_cnt_b;

    logic               w_grant;
    logic               w_accept;
    logic               w_bit;
    logic               w_hit_a;
    logic               w_hit_b;
    logic [CNT_W-1:0]   w_cnt_a_nxt;
    logic [CNT_W-1:0]   w_cnt_b_nxt;

    // On a tie, grant the requester that was not served last. Otherwise grant
    // whichever requester is valid. The result is ignored when neither is valid.
    assign w_grant = (req0_valid && req1_valid) ? ~r_last : req1_valid;

    // Detector. The history holds the previous two bits of this job only. The
    // bit counter keeps the first two bits of a job from counting as hits.
    assign w_bit   = r_data[WIDTH-1];
    assign w_hit_a = (r_bit_cnt >= BW'(2)) && ({r_hist, w_bit} == 3'b010);
    assign w_hit_b = (r_bit_cnt >= BW'(2)) && ({r_hist, w_bit} == 3'b101);

    assign w_cnt_a_nxt = (w_hit_a && (r_cnt_a != CNT_MAX)) ? r_cnt_a + CNT_W'(1) : r_cnt_a;
    assign w_cnt_b_nxt = (w_hit_b && (r_cnt_b != CNT_MAX)) ? r_cnt_b + CNT_W'(1) : r_cnt_b;

    // Next-state and handshake logic
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = req0_valid && !w_grant;
                req1_ready = req1_valid &&  w_grant;
                if (req0_valid || req1_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: job capture, serial shift, counting, result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;   // requester 0 wins the first tie
            r_bit_cnt   <= '0;
            r_hist      <= '0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_res_id    <= 1'b0;
            r_res_cnt_a <= '0;
            r_res_cnt_b <= '0;
        end else if (w_accept) begin
            r_data    <= w_grant ? req1_data : req0_data;
            r_id      <= w_grant;
            r_last    <= w_grant;
            r_bit_cnt <= '0;
            r_hist    <= '0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_data    <= {r_data[WIDTH-2:0], 1'b0};
            r_hist    <= {r_hist[0], w_bit};
            r_bit_cnt <= r_bit_cnt + BW'(1);
            r_cnt_a   <= w_cnt_a_nxt;
            r_cnt_b   <= w_cnt_b_nxt;
            // The result registers load the final counts together with the
            // last bit. They keep these values until the next job finishes.
            if (r_bit_cnt == LAST_BIT) begin
                r_res_id    <= r_id;
                r_res_cnt_a <= w_cnt_a_nxt;
                r_res_cnt_b <= w_cnt_b_nxt;
            end
        end
    end

    assign res_valid = (r_state == ST_RESULT);
    assign res_id    = r_res_id;
    assign res_cnt_a = r_res_cnt_a;
    assign res_cnt_b = r_res_cnt_b;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: doc/pattern_stream_sched.md
PATTERN_STREAM_SCHED -- requirements
Module: pattern_stream_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per job word (WIDTH >= 3).
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of each hit counter (2^CNT_W > WIDTH-2).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req0_valid  input  1  requester 0 offers a job word.
REQ-006 SHALL have port req0_data  input  WIDTH  requester 0 job word.
REQ-007 SHALL have port req0_ready  output  1  requester 0 word accepted this cycle if req0_valid is high.
REQ-008 SHALL have ports req1_valid, req1_data, req1_ready, identical to REQ-005..007, for requester 1.
REQ-009 SHALL have port res_valid  output  1  result fields are valid.
REQ-010 SHALL have port res_id  output  1  requester index owning the result.
REQ-011 SHALL have port res_cnt_a  output  CNT_W  count of "010" hits in the job.
REQ-012 SHALL have port res_cnt_b  output  CNT_W  count of "101" hits in the job.
REQ-013 SHALL have port res_ready  input  1  consumer accepts result when high with res_valid.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, SHIFT, RESULT; one job is processed at a time on the single shared serial detector.
REQ-016 In IDLE, SHALL select the grant by round-robin: if exactly one req*_valid is high, grant it; if both, grant the requester not granted last.
REQ-017 req_k_ready SHALL be high only in IDLE and only for the granted k, and SHALL be computed combinationally from the current state and valid inputs.
REQ-018 On acceptance (valid&&ready) in cycle t: SHALL latch the data and requester id, clear the detector history and both counters, update the last-granted pointer, and enter SHIFT at t+1.
REQ-019 In SHIFT, SHALL feed one bit per cycle, MSB first, for exactly WIDTH cycles (t+1..t+WIDTH) into the detector.
REQ-020 The detector SHALL be a Mealy detector over the last three bits of the current job, with overlap allowed; history never spans jobs.
REQ-021 Upon each bit whose preceding two bits and itself form 010, SHALL increment cnt_a; for 101, SHALL increment cnt_b; for the first two bits of a job, no increment.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 After the WIDTH-th bit, SHALL enter RESULT at t+WIDTH+1 with res_valid=1 and res_id/res_cnt_a/res_cnt_b holding the final values.
REQ-024 In RESULT, outputs SHALL stay stable while res_ready=0; on res_valid&&res_ready, SHALL return to IDLE on the next cycle.
REQ-025 No requester SHALL be accepted in SHIFT or RESULT; req*_ready=0 there regardless of valid.
REQ-026 res_cnt_a/res_cnt_b/res_id SHALL keep their last result values outside RESULT; res_valid=0 outside RESULT.
REQ-027 Minimum job period SHALL be WIDTH+2 cycles (accept, WIDTH shifts, one result cycle with res_ready=1).

Reset
REQ-028 While reset_n=0, SHALL force state IDLE, res_valid=0, res_id=0, res_cnt_a=0, res_cnt_b=0, busy=0, detector history and counters cleared, last-granted pointer=1 (so requester 0 wins first tie).
REQ-029 Assertion of reset_n mid-SHIFT or mid-RESULT SHALL abandon the job with no result emitted; after release, operation SHALL restart from IDLE.

Verification
REQ-030 Req0 word 8'b01101010 accepted at cycle t, res_ready=1 -> res_valid at t+9, res_id=0, res_cnt_a=2, res_cnt_b=2, busy high t+1..t+9.
REQ-031 Both requesters valid after reset with 8'b10101010 (req0) and 8'b00000000 (req1) -> req0 served first (a=3, b=3), then req1 (a=0, b=0), res_id 0 then 1.
REQ-032 res_ready held 0 for 5 cycles in RESULT -> res_valid and fields stable all 5 cycles, both ready outputs 0, IDLE one cycle after res_ready rises.
REQ-033 Req1 held valid continuously while req0 alternately valid -> grants alternate 0,1,0,1; no requester accepted twice in a row when the other is waiting.
REQ-034 reset_n pulsed low at the 4th SHIFT cycle -> no res_valid, all outputs per REQ-028, and the next accepted job yields correct counts unaffected by prior bits.
